mt9v034_serial_emulator: RTL and testbench



---
 rtl/mt9v034_pkg.sv | 43 ++++
 rtl/mt9v034_word_serializer.sv | 47 ++++
 rtl/mt9v034_serial_emulator.sv | 210 +++++++++++++++++++++
 tb/tb_mt9v034_serial_emulator.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt9v034_pkg.sv
// Shared constants, FSM state type and word helpers for the MT9V034 serial emulator.
package mt9v034_pkg;

   localparam int WORD_BITS = 12;
   localparam int PIX_BITS  = 10;

   localparam logic [PIX_BITS-1:0] SYNC_PREAMBLE = 10'h3FF;
   localparam logic [PIX_BITS-1:0] SYNC_ZERO     = 10'h000;
   localparam logic [PIX_BITS-1:0] CODE_LS       = 10'h001;
   localparam logic [PIX_BITS-1:0] CODE_LE       = 10'h002;
   localparam logic [PIX_BITS-1:0] CODE_FS       = 10'h004;
   localparam logic [PIX_BITS-1:0] CODE_FE       = 10'h008;
   localparam logic [PIX_BITS-1:0] PIX_CLAMP     = 10'h3FE;
   localparam logic [PIX_BITS-1:0] LFSR_SEED     = 10'h001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FS_SYNC,
      ST_LS_SYNC,
      ST_PIXELS,
      ST_LE_SYNC,
      ST_HBLANK,
      ST_FE_SYNC,
      ST_VBLANK
   } tx_state_t;

   // Pixel data must never imitate the sync preamble.
   function automatic logic [PIX_BITS-1:0] clamp_pixel(input logic [PIX_BITS-1:0] value);
      return (value == SYNC_PREAMBLE) ? PIX_CLAMP : value;
   endfunction

   function automatic logic [PIX_BITS-1:0] sync_word(input logic [1:0] idx,
                                                     input logic [PIX_BITS-1:0] code);
      logic [PIX_BITS-1:0] word;
      case (idx)
         2'd0:    word = SYNC_PREAMBLE;
         2'd1:    word = SYNC_ZERO;
         default: word = code;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/mt9v034_word_serializer.sv
// 12-bit word shifter: start bit, ten data bits LSB first, stop bit.
// word_req is high during the bit-11 cycle (or before the first word) so the next word loads seamlessly.
module mt9v034_word_serializer
   import mt9v034_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [PIX_BITS-1:0] load_data,
   output logic                word_req,
   output logic                first_word,
   output logic                tx_bit,
   output logic                word_strobe
);

   localparam int CW = $clog2(WORD_BITS);
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);

   logic [CW-1:0]       bit_cnt;
   logic [PIX_BITS-1:0] shift_reg;
   logic                running;

   assign first_word = ~running;
   assign word_req   = ~running | (bit_cnt == LAST_BIT);

   // Zeros shifted in behind the data provide the stop bit for free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running     <= 1'b0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         tx_bit      <= 1'b0;
         word_strobe <= 1'b0;
      end else if (word_req) begin
         running     <= 1'b1;
         bit_cnt     <= '0;
         shift_reg   <= load_data;
         tx_bit      <= 1'b1;
         word_strobe <= 1'b1;
      end else begin
         bit_cnt     <= bit_cnt + CW'(1);
         shift_reg   <= {1'b0, shift_reg[PIX_BITS-1:1]};
         tx_bit      <= shift_reg[0];
         word_strobe <= 1'b0;
      end
   end

endmodule

// File: rtl/mt9v034_serial_emulator.sv
// Synthetic MT9V034 frame source: sync words, pixel pattern and blanking, serialised one bit per clock.
// Define MT9V034_TX_PRBS_EN for LFSR pixel data; otherwise an (x + y) ramp is sent.
module mt9v034_serial_emulator
   import mt9v034_pkg::*;
#(
   parameter int C_Width  = 752,
   parameter int C_Height = 480,
   parameter int C_HBlank = 61,
   parameter int C_VBlank = 45
)
(
   input  logic                ClkIn,
   input  logic                Rst,
   input  logic                Enable,
   output logic                TxBit,
   output logic                WordStrobe,
   output logic                FrameActive,
   output logic                LineActive,
   output logic [PIX_BITS-1:0] PixelValue
);

   localparam int XW   = (C_Width  > 1) ? $clog2(C_Width)  : 1;
   localparam int YW   = (C_Height > 1) ? $clog2(C_Height) : 1;
   localparam int BMAX = (C_HBlank > C_VBlank) ? C_HBlank : C_VBlank;
   localparam int BW   = (BMAX > 0) ? $clog2(BMAX + 1) : 1;

   localparam logic [XW-1:0] X_LAST  = XW'(C_Width - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(C_Height - 1);
   localparam logic [BW-1:0] HB_LAST = BW'((C_HBlank > 0) ? C_HBlank - 1 : 0);
   localparam logic [BW-1:0] VB_LAST = BW'((C_VBlank > 0) ? C_VBlank - 1 : 0);

   tx_state_t           state_q, state_d;
   logic [1:0]          sync_q, sync_d;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic [BW-1:0]       blank_q, blank_d;
   logic [PIX_BITS-1:0] word_data;
   logic [PIX_BITS-1:0] pix_raw;
   logic                word_req;
   logic                first_word;

   // The registered state describes the word on the line; *_d describes the word loaded at the next request.
   always_comb begin
      state_d = state_q;
      sync_d  = sync_q;
      x_d     = x_q;
      y_d     = y_q;
      blank_d = blank_q;
      if (first_word) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (Enable) begin
                  state_d = ST_FS_SYNC;
                  sync_d  = '0;
                  x_d     = '0;
                  y_d     = '0;
               end
            end
            ST_FS_SYNC: begin
               if (sync_q == 2'd2) begin
                  state_d = ST_LS_SYNC;
                  sync_d  = '0;
               end else begin
                  sync_d = sync_q + 2'd1;
               end
            end
            ST_LS_SYNC: begin
               if (sync_q == 2'd2) begin
                  state_d = ST_PIXELS;
                  sync_d  = '0;
                  x_d     = '0;
               end else begin
                  sync_d = sync_q + 2'd1;
               end
            end
            ST_PIXELS: begin
               if (x_q == X_LAST) begin
                  state_d = ST_LE_SYNC;
                  sync_d  = '0;
                  x_d     = '0;
               end else begin
                  x_d = x_q + XW'(1);
               end
            end
            ST_LE_SYNC: begin
               if (sync_q != 2'd2) begin
                  sync_d = sync_q + 2'd1;
               end else if (y_q == Y_LAST) begin
                  state_d = ST_FE_SYNC;
                  sync_d  = '0;
                  y_d     = '0;
               end else begin
                  y_d    = y_q + YW'(1);
                  sync_d = '0;
                  if (C_HBlank == 0) begin
                     state_d = ST_LS_SYNC;
                  end else begin
                     state_d = ST_HBLANK;
                     blank_d = '0;
                  end
               end
            end
            ST_HBLANK: begin
               if (blank_q == HB_LAST) begin
                  state_d = ST_LS_SYNC;
                  sync_d  = '0;
                  blank_d = '0;
               end else begin
                  blank_d = blank_q + BW'(1);
               end
            end
            ST_FE_SYNC: begin
               if (sync_q != 2'd2) begin
                  sync_d = sync_q + 2'd1;
               end else if (C_VBlank == 0) begin
                  state_d = Enable ? ST_FS_SYNC : ST_IDLE;
                  sync_d  = '0;
                  x_d     = '0;
                  y_d     = '0;
                  blank_d = '0;
               end else begin
                  state_d = ST_VBLANK;
                  sync_d  = '0;
                  blank_d = '0;
               end
            end
            ST_VBLANK: begin
               if (blank_q == VB_LAST) begin
                  state_d = Enable ? ST_FS_SYNC : ST_IDLE;
                  sync_d  = '0;
                  x_d     = '0;
                  y_d     = '0;
                  blank_d = '0;
               end else begin
                  blank_d = blank_q + BW'(1);
               end
            end
         endcase
      end
   end

`ifdef MT9V034_TX_PRBS_EN
   logic [PIX_BITS-1:0] lfsr_q;

   // x^10 + x^7 + 1, reseeded at the first FS word and stepped once per pixel word.
   always_ff @(posedge ClkIn or posedge Rst) begin
      if (Rst) begin
         lfsr_q <= LFSR_SEED;
      end else if (word_req) begin
         if (state_d == ST_FS_SYNC && sync_d == 2'd0) begin
            lfsr_q <= LFSR_SEED;
         end else if (state_d == ST_PIXELS) begin
            lfsr_q <= {lfsr_q[PIX_BITS-2:0], lfsr_q[9] ^ lfsr_q[6]};
         end
      end
   end

   assign pix_raw = lfsr_q;
`else
   assign pix_raw = PIX_BITS'(x_d) + PIX_BITS'(y_d);
`endif

   always_comb begin
      word_data = SYNC_ZERO;
      case (state_d)
         ST_FS_SYNC: word_data = sync_word(sync_d, CODE_FS);
         ST_LS_SYNC: word_data = sync_word(sync_d, CODE_LS);
         ST_LE_SYNC: word_data = sync_word(sync_d, CODE_LE);
         ST_FE_SYNC: word_data = sync_word(sync_d, CODE_FE);
         ST_PIXELS:  word_data = clamp_pixel(pix_raw);
         default:    word_data = SYNC_ZERO;
      endcase
   end

   // Flags are loaded together with the word so they stay aligned with TxBit.
   always_ff @(posedge ClkIn or posedge Rst) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         sync_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         blank_q     <= '0;
         FrameActive <= 1'b0;
         LineActive  <= 1'b0;
         PixelValue  <= '0;
      end else if (word_req) begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         x_q         <= x_d;
         y_q         <= y_d;
         blank_q     <= blank_d;
         FrameActive <= (state_d != ST_IDLE) && (state_d != ST_VBLANK);
         LineActive  <= (state_d == ST_PIXELS);
         PixelValue  <= word_data;
      end
   end

   mt9v034_word_serializer u_serializer (
      .clk         (ClkIn),
      .rst         (Rst),
      .load_data   (word_data),
      .word_req    (word_req),
      .first_word  (first_word),
      .tx_bit      (TxBit),
      .word_strobe (WordStrobe)
   );

endmodule

// File: tb/tb_mt9v034_serial_emulator.sv
// Directed bench for mt9v034_serial_emulator: a small 4x2 frame instance and a 1030-wide ramp instance.
module tb_mt9v034_serial_emulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       enable_w;
   logic       tx, ws, fa, la;
   logic [9:0] pv;
   logic       tx_w, ws_w, fa_w, la_w;
   logic [9:0] pv_w;

   int checks   = 0;
   int failures = 0;

   // Hand-derived word sequence for C_Width=4, C_Height=2, C_HBlank=2, C_VBlank=3.
   localparam logic [9:0] FRAME_WORDS [0:30] = '{
      10'h3FF, 10'h000, 10'h004,
      10'h3FF, 10'h000, 10'h001,
      10'h000, 10'h001, 10'h002, 10'h003,
      10'h3FF, 10'h000, 10'h002,
      10'h000, 10'h000,
      10'h3FF, 10'h000, 10'h001,
      10'h001, 10'h002, 10'h003, 10'h004,
      10'h3FF, 10'h000, 10'h002,
      10'h3FF, 10'h000, 10'h008,
      10'h000, 10'h000, 10'h000
   };

   always #5 clk = ~clk;

   mt9v034_serial_emulator #(
      .C_Width(4), .C_Height(2), .C_HBlank(2), .C_VBlank(3)
   ) dut (
      .ClkIn(clk), .Rst(rst), .Enable(enable), .TxBit(tx), .WordStrobe(ws),
      .FrameActive(fa), .LineActive(la), .PixelValue(pv)
   );

   mt9v034_serial_emulator #(
      .C_Width(1030), .C_Height(2), .C_HBlank(0), .C_VBlank(0)
   ) dut_wide (
      .ClkIn(clk), .Rst(rst), .Enable(enable_w), .TxBit(tx_w), .WordStrobe(ws_w),
      .FrameActive(fa_w), .LineActive(la_w), .PixelValue(pv_w)
   );

   // Entered at a negedge showing a start bit; returns at the next word's start bit.
   task automatic read_word(input bit wide, output logic [9:0] data, output logic [9:0] pv0,
                            output int fa_cnt, output int la_cnt, output int frame_err);
      data      = '0;
      fa_cnt    = 0;
      la_cnt    = 0;
      frame_err = 0;
      pv0       = wide ? pv_w : pv;
      for (int b = 0; b < 12; b++) begin
         logic t, s, f, l;
         t = wide ? tx_w : tx;
         s = wide ? ws_w : ws;
         f = wide ? fa_w : fa;
         l = wide ? la_w : la;
         if (b == 0) begin
            if (t !== 1'b1 || s !== 1'b1) frame_err++;
         end else begin
            if (s !== 1'b0) frame_err++;
            if (b == 11 && t !== 1'b0) frame_err++;
            if (b <= 10) data[b-1] = t;
         end
         if (f === 1'b1) fa_cnt++;
         if (l === 1'b1) la_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic wait_word_start(input bit wide, output bit found);
      found = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if ((wide ? ws_w : ws) === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      enable   = 1'b0;
      enable_w = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (tx !== 1'b0 || ws !== 1'b0 || fa !== 1'b0 || la !== 1'b0 || pv !== 10'h000) begin
         failures++;
         $display("[TB] FAIL reset_outputs: tx=%b ws=%b fa=%b la=%b pv=%h, required all 0", tx, ws, fa, la, pv);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || ws !== 1'b1 || fa !== 1'b0 || la !== 1'b0 || pv !== 10'h000) begin
         failures++;
         $display("[TB] FAIL first_word_start: tx=%b ws=%b fa=%b la=%b pv=%h, required tx=1 ws=1 fa=0 la=0 pv=000",
                  tx, ws, fa, la, pv);
      end
   endtask

   task automatic test_idle();
      logic exp;
      for (int i = 0; i < 50; i++) begin
         exp = ((i % 12) == 0);
         checks++;
         if (tx !== exp || ws !== exp || fa !== 1'b0 || la !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_cycle[%0d]: tx=%b ws=%b fa=%b la=%b, required tx=%b ws=%b fa=0 la=0",
                     i, tx, ws, fa, la, exp, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single_frame();
      bit         found;
      logic [9:0] d, p;
      int         fa_c, la_c, fe, exp_fa, exp_la;
      wait_word_start(1'b0, found);
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL frame_align: no word strobe seen=%b, required 1", found);
      end
      enable = 1'b1;
      read_word(1'b0, d, p, fa_c, la_c, fe);
      enable = 1'b0;
      for (int w = 0; w < 31; w++) begin
         read_word(1'b0, d, p, fa_c, la_c, fe);
         exp_fa = (w < 28) ? 12 : 0;
         exp_la = ((w >= 6 && w <= 9) || (w >= 18 && w <= 21)) ? 12 : 0;
         checks++;
         if (d !== FRAME_WORDS[w] || p !== FRAME_WORDS[w] || fe !== 0 || fa_c !== exp_fa || la_c !== exp_la) begin
            failures++;
            $display("[TB] FAIL frame_word[%0d]: data=%h pv=%h frame_err=%0d fa_cycles=%0d la_cycles=%0d, required data=pv=%h frame_err=0 fa_cycles=%0d la_cycles=%0d",
                     w, d, p, fe, fa_c, la_c, FRAME_WORDS[w], exp_fa, exp_la);
         end
      end
      for (int w = 0; w < 2; w++) begin
         read_word(1'b0, d, p, fa_c, la_c, fe);
         checks++;
         if (d !== 10'h000 || fe !== 0 || fa_c !== 0 || la_c !== 0) begin
            failures++;
            $display("[TB] FAIL after_frame_idle[%0d]: data=%h frame_err=%0d fa_cycles=%0d la_cycles=%0d, required 000/0/0/0",
                     w, d, fe, fa_c, la_c);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit         found;
      logic [9:0] d, p;
      int         fa_c, la_c, fe, exp_fa, exp_la;
      wait_word_start(1'b0, found);
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL b2b_align: no word strobe seen=%b, required 1", found);
      end
      enable = 1'b1;
      read_word(1'b0, d, p, fa_c, la_c, fe);
      for (int f = 0; f < 2; f++) begin
         for (int w = 0; w < 31; w++) begin
            // Second frame: drop Enable during line 0 pixels; the frame must still complete.
            if (f == 1 && w == 7) enable = 1'b0;
            read_word(1'b0, d, p, fa_c, la_c, fe);
            exp_fa = (w < 28) ? 12 : 0;
            exp_la = ((w >= 6 && w <= 9) || (w >= 18 && w <= 21)) ? 12 : 0;
            checks++;
            if (d !== FRAME_WORDS[w] || p !== FRAME_WORDS[w] || fe !== 0 || fa_c !== exp_fa || la_c !== exp_la) begin
               failures++;
               $display("[TB] FAIL b2b_word[%0d][%0d]: data=%h pv=%h frame_err=%0d fa_cycles=%0d la_cycles=%0d, required data=pv=%h frame_err=0 fa_cycles=%0d la_cycles=%0d",
                        f, w, d, p, fe, fa_c, la_c, FRAME_WORDS[w], exp_fa, exp_la);
            end
         end
      end
      for (int w = 0; w < 2; w++) begin
         read_word(1'b0, d, p, fa_c, la_c, fe);
         checks++;
         if (d !== 10'h000 || fe !== 0 || fa_c !== 0) begin
            failures++;
            $display("[TB] FAIL no_second_fs[%0d]: data=%h frame_err=%0d fa_cycles=%0d, required 000/0/0",
                     w, d, fe, fa_c);
         end
      end
   endtask

   task automatic test_wide_ramp();
      bit         found;
      logic [9:0] d, p, exp;
      int         fa_c, la_c, fe;
      wait_word_start(1'b1, found);
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL wide_align: no word strobe seen=%b, required 1", found);
      end
      enable_w = 1'b1;
      read_word(1'b1, d, p, fa_c, la_c, fe);
      enable_w = 1'b0;
      for (int w = 0; w < 6; w++) begin
         read_word(1'b1, d, p, fa_c, la_c, fe);
         checks++;
         if (d !== FRAME_WORDS[w] || fe !== 0 || fa_c !== 12) begin
            failures++;
            $display("[TB] FAIL wide_sync[%0d]: data=%h frame_err=%0d fa_cycles=%0d, required data=%h frame_err=0 fa_cycles=12",
                     w, d, fe, fa_c, FRAME_WORDS[w]);
         end
      end
      for (int x = 0; x < 1026; x++) begin
         read_word(1'b1, d, p, fa_c, la_c, fe);
         exp = 10'(x % 1024);
         if (exp == 10'h3FF) exp = 10'h3FE;
         checks++;
         if (d !== exp || p !== exp || fe !== 0 || la_c !== 12) begin
            failures++;
            $display("[TB] FAIL wide_pixel[%0d]: data=%h pv=%h frame_err=%0d la_cycles=%0d, required data=pv=%h frame_err=0 la_cycles=12",
                     x, d, p, fe, la_c, exp);
         end
      end
   endtask

   task automatic test_reset_mid_word();
      bit         found;
      logic [9:0] d, p;
      int         fa_c, la_c, fe;
      wait_word_start(1'b0, found);
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL rst_align: no word strobe seen=%b, required 1", found);
      end
      enable = 1'b1;
      read_word(1'b0, d, p, fa_c, la_c, fe);
      enable = 1'b0;
      for (int w = 0; w < 6; w++) read_word(1'b0, d, p, fa_c, la_c, fe);
      repeat (5) @(negedge clk);
      checks++;
      if (la !== 1'b1 || fa !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rst_precondition: la=%b fa=%b at pixel bit 5, required la=1 fa=1", la, fa);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b0 || ws !== 1'b0 || fa !== 1'b0 || la !== 1'b0 || pv !== 10'h000) begin
         failures++;
         $display("[TB] FAIL rst_mid_word: tx=%b ws=%b fa=%b la=%b pv=%h, required all 0", tx, ws, fa, la, pv);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || ws !== 1'b1 || fa !== 1'b0 || la !== 1'b0 || pv !== 10'h000) begin
         failures++;
         $display("[TB] FAIL rst_restart: tx=%b ws=%b fa=%b la=%b pv=%h, required tx=1 ws=1 fa=0 la=0 pv=000",
                  tx, ws, fa, la, pv);
      end
      for (int w = 0; w < 2; w++) begin
         read_word(1'b0, d, p, fa_c, la_c, fe);
         checks++;
         if (d !== 10'h000 || fe !== 0 || fa_c !== 0 || la_c !== 0) begin
            failures++;
            $display("[TB] FAIL rst_idle_word[%0d]: data=%h frame_err=%0d fa_cycles=%0d la_cycles=%0d, required 000/0/0/0",
                     w, d, fe, fa_c, la_c);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_frame();
      test_back_to_back();
      test_wide_ramp();
      test_reset_mid_word();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: time limit reached before summary, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
